// File: rtl/if_fetch_queue_if.sv
// ---------------------------------------------------------------------------
// if_fetch_queue_if
// Groups the buses around the fetch queue:
//   redirect / redirect_pc : flush request and its target from the back end
//   im_req / im_addr       : instruction-memory request (driven by fetch)
//   im_ack / im_data       : memory acceptance and returned instruction word
//   id_valid / id_ready    : decode-side valid/ready handshake
//   id_ins / id_pc / id_npc: head instruction, its PC and PC + 4
// master : the fetch stage
// slave  : the environment (memory, decode, redirect source)
// ---------------------------------------------------------------------------
interface if_fetch_queue_if #(
    parameter int XLEN = 32
);
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            im_req;
    logic [XLEN-1:0] im_addr;
    logic            im_ack;
    logic [31:0]     im_data;
    logic            id_valid;
    logic            id_ready;
    logic [31:0]     id_ins;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_npc;

    modport master (
        input  redirect, redirect_pc, im_ack, im_data, id_ready,
        output im_req, im_addr, id_valid, id_ins, id_pc, id_npc
    );

    modport slave (
        output redirect, redirect_pc, im_ack, im_data, id_ready,
        input  im_req, im_addr, id_valid, id_ins, id_pc, id_npc
    );
endinterface

// File: rtl/if_fetch_queue.sv
// ---------------------------------------------------------------------------
// if_fetch_queue
// Instruction-fetch stage with a QDEPTH-entry {pc, ins} queue. Requests are
// issued to a variable-latency instruction memory over a req/ack handshake
// (at most one outstanding) and decode drains the queue via valid/ready.
// A redirect flushes the queue and restarts fetch at the new target; a
// request already in flight when the redirect arrives is waited out and its
// data dropped.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : if_fetch_queue_if.master (redirect, im_*, id_* signals)
// ---------------------------------------------------------------------------
module if_fetch_queue #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h80000000),
    parameter int              QDEPTH   = 4
) (
    input logic              clk,
    input logic              rst,
    if_fetch_queue_if.master bus
);
    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD,
        DISCARD
    } state_t;

    state_t            state;
    logic              im_req_q;
    logic [XLEN-1:0]   im_addr_q;
    logic [XLEN-1:0]   fetch_pc;
    logic [CNT_W-1:0]  count;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;

    logic [XLEN-1:0]   mem_pc  [QDEPTH];
    logic [31:0]       mem_ins [QDEPTH];

    logic              push;
    logic              pop;
    logic [CNT_W:0]    count_next;
    logic              slot_free;
    logic [XLEN-1:0]   redirect_target;
    logic [1:0]        unused_pc_bits;

    assign redirect_target = {bus.redirect_pc[XLEN-1:2], 2'b00};
    assign unused_pc_bits  = bus.redirect_pc[1:0];

    // Occupancy after this cycle's push/pop, one bit wider so it can never
    // alias; a new request is launched only if this leaves a free slot.
    assign push       = (state == FETCH) && bus.im_ack;
    assign pop        = (count != '0) && bus.id_ready;
    assign count_next = {1'b0, count} + {{CNT_W{1'b0}}, push}
                        - {{CNT_W{1'b0}}, pop};
    assign slot_free  = count_next < (CNT_W+1)'(QDEPTH);

    assign bus.im_req   = im_req_q;
    assign bus.im_addr  = im_addr_q;
    assign bus.id_valid = (count != '0);
    assign bus.id_ins   = mem_ins[rd_ptr];
    assign bus.id_pc    = mem_pc[rd_ptr];
    assign bus.id_npc   = mem_pc[rd_ptr] + XLEN'(4);

    // Queue storage carries no reset; entries are only visible through count.
    always_ff @(posedge clk) begin
        if (!rst && !bus.redirect && push) begin
            mem_pc[wr_ptr]  <= im_addr_q;
            mem_ins[wr_ptr] <= bus.im_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            im_req_q  <= 1'b0;
            im_addr_q <= RESET_PC;
            fetch_pc  <= RESET_PC;
            count     <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
        end else if (bus.redirect) begin
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fetch_pc <= redirect_target;
            case (state)
                FETCH: begin
                    // With ack the old request is complete and can be
                    // replaced right away; without it we must wait it out.
                    if (bus.im_ack) begin
                        im_req_q  <= 1'b1;
                        im_addr_q <= redirect_target;
                    end else begin
                        state <= DISCARD;
                    end
                end
                DISCARD: begin
                end
                default: begin
                    im_req_q  <= 1'b1;
                    im_addr_q <= redirect_target;
                    state     <= FETCH;
                end
            endcase
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_next[CNT_W-1:0];

            case (state)
                IDLE: begin
                    im_req_q  <= 1'b1;
                    im_addr_q <= fetch_pc;
                    state     <= FETCH;
                end
                FETCH: begin
                    if (bus.im_ack) begin
                        if (slot_free) begin
                            im_addr_q <= im_addr_q + XLEN'(4);
                        end else begin
                            im_req_q <= 1'b0;
                            fetch_pc <= im_addr_q + XLEN'(4);
                            state    <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (slot_free) begin
                        im_req_q  <= 1'b1;
                        im_addr_q <= fetch_pc;
                        state     <= FETCH;
                    end
                end
                DISCARD: begin
                    // Stale word from the flushed request is simply not pushed.
                    if (bus.im_ack) begin
                        im_req_q  <= 1'b1;
                        im_addr_q <= fetch_pc;
                        state     <= FETCH;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_if_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_queue
// Directed, table-driven bench for if_fetch_queue (XLEN=32, QDEPTH=4).
// Each vector gives the inputs for one cycle and the outputs expected in
// that cycle (before the next rising edge). A hand-written sequence then
// covers redirect out of IDLE and sustained 1 instruction/cycle streaming.
// ---------------------------------------------------------------------------
module tb_if_fetch_queue;
    localparam int NVEC = 41;

    typedef struct {
        logic        rst;
        logic        redir;
        logic [31:0] rpc;
        logic        ack;
        logic [31:0] data;
        logic        rdy;
        logic        chk;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_val;
        logic [31:0] e_pc;
        logic [31:0] e_ins;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    vec_t vecs [NVEC];

    if_fetch_queue_if #(.XLEN(32)) bus ();

    if_fetch_queue #(
        .XLEN    (32),
        .RESET_PC(32'h80000000),
        .QDEPTH  (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic rd, input logic [31:0] rp,
                                input logic a, input logic [31:0] d, input logic y,
                                input logic c, input logic er, input logic [31:0] ea,
                                input logic ev, input logic [31:0] ep, input logic [31:0] ei);
        vec_t v;
        v.rst = r; v.redir = rd; v.rpc = rp; v.ack = a; v.data = d; v.rdy = y;
        v.chk = c; v.e_req = er; v.e_addr = ea; v.e_val = ev; v.e_pc = ep; v.e_ins = ei;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, check the registered
    // state just after, and leave the rising edge to the next call.
    task automatic applyStimulus(input vec_t v, input string tag);
        @(negedge clk);
        rst             = v.rst;
        bus.redirect    = v.redir;
        bus.redirect_pc = v.rpc;
        bus.im_ack      = v.ack;
        bus.im_data     = v.data;
        bus.id_ready    = v.rdy;
        #1;
        if (v.chk) begin
            checkOutput({tag, " im_req"},   {31'd0, bus.im_req},   {31'd0, v.e_req});
            checkOutput({tag, " im_addr"},  bus.im_addr,           v.e_addr);
            checkOutput({tag, " id_valid"}, {31'd0, bus.id_valid}, {31'd0, v.e_val});
            if (v.e_val) begin
                checkOutput({tag, " id_pc"},  bus.id_pc,  v.e_pc);
                checkOutput({tag, " id_ins"}, bus.id_ins, v.e_ins);
                checkOutput({tag, " id_npc"}, bus.id_npc, v.e_pc + 32'd4);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst = 1'b1;
        bus.redirect = 1'b0; bus.redirect_pc = '0; bus.im_ack = 1'b0;
        bus.im_data = '0; bus.id_ready = 1'b0;

        //              rst rd rpc           ack data          rdy chk req addr          val pc            ins
        // streaming from reset
        vecs[0]  = mk(1, 0, 32'h0,        0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0,        32'h0);
        vecs[1]  = mk(0, 0, 32'h0,        0, 32'h0,        1, 1, 0, 32'h80000000, 0, 32'h0,        32'h0);
        vecs[2]  = mk(0, 0, 32'h0,        1, 32'hD0000000, 1, 1, 1, 32'h80000000, 0, 32'h0,        32'h0);
        vecs[3]  = mk(0, 0, 32'h0,        1, 32'hD0000001, 1, 1, 1, 32'h80000004, 1, 32'h80000000, 32'hD0000000);
        vecs[4]  = mk(0, 0, 32'h0,        1, 32'hD0000002, 1, 1, 1, 32'h80000008, 1, 32'h80000004, 32'hD0000001);
        // stall fills the queue, then release
        vecs[5]  = mk(1, 0, 32'h0,        0, 32'h0,        0, 1, 1, 32'h8000000C, 1, 32'h80000008, 32'hD0000002);
        vecs[6]  = mk(0, 0, 32'h0,        0, 32'h0,        0, 1, 0, 32'h80000000, 0, 32'h0,        32'h0);
        vecs[7]  = mk(0, 0, 32'h0,        1, 32'hE0000000, 0, 1, 1, 32'h80000000, 0, 32'h0,        32'h0);
        vecs[8]  = mk(0, 0, 32'h0,        1, 32'hE0000001, 0, 1, 1, 32'h80000004, 1, 32'h80000000, 32'hE0000000);
        vecs[9]  = mk(0, 0, 32'h0,        1, 32'hE0000002, 0, 1, 1, 32'h80000008, 1, 32'h80000000, 32'hE0000000);
        vecs[10] = mk(0, 0, 32'h0,        1, 32'hE0000003, 0, 1, 1, 32'h8000000C, 1, 32'h80000000, 32'hE0000000);
        vecs[11] = mk(0, 0, 32'h0,        0, 32'h0,        0, 1, 0, 32'h8000000C, 1, 32'h80000000, 32'hE0000000);
        vecs[12] = mk(0, 0, 32'h0,        0, 32'h0,        1, 1, 0, 32'h8000000C, 1, 32'h80000000, 32'hE0000000);
        vecs[13] = mk(0, 0, 32'h0,        1, 32'hE0000004, 1, 1, 1, 32'h80000010, 1, 32'h80000004, 32'hE0000001);
        vecs[14] = mk(0, 0, 32'h0,        0, 32'h0,        1, 1, 1, 32'h80000014, 1, 32'h80000008, 32'hE0000002);
        vecs[15] = mk(0, 0, 32'h0,        0, 32'h0,        1, 1, 1, 32'h80000014, 1, 32'h8000000C, 32'hE0000003);
        vecs[16] = mk(0, 0, 32'h0,        0, 32'h0,        1, 1, 1, 32'h80000014, 1, 32'h80000010, 32'hE0000004);
        vecs[17] = mk(0, 0, 32'h0,        0, 32'h0,        1, 1, 1, 32'h80000014, 0, 32'h0,        32'h0);
        // slow ack, redirect while a request is waiting
        vecs[18] = mk(0, 0, 32'h0,        1, 32'hF0000000, 0, 1, 1, 32'h80000014, 0, 32'h0,        32'h0);
        vecs[19] = mk(0, 0, 32'h0,        0, 32'h0,        0, 1, 1, 32'h80000018, 1, 32'h80000014, 32'hF0000000);
        vecs[20] = mk(0, 0, 32'h0,        0, 32'h0,        0, 1, 1, 32'h80000018, 1, 32'h80000014, 32'hF0000000);
        vecs[21] = mk(0, 1, 32'h80001002, 0, 32'h0,        0, 1, 1, 32'h80000018, 1, 32'h80000014, 32'hF0000000);
        vecs[22] = mk(0, 0, 32'h0,        0, 32'h0,        0, 1, 1, 32'h80000018, 0, 32'h0,        32'h0);
        vecs[23] = mk(0, 0, 32'h0,        1, 32'hBAD0BAD0, 0, 1, 1, 32'h80000018, 0, 32'h0,        32'h0);
        vecs[24] = mk(0, 0, 32'h0,        0, 32'h0,        0, 1, 1, 32'h80001000, 0, 32'h0,        32'h0);
        // redirect together with ack and pop at count=2
        vecs[25] = mk(0, 0, 32'h0,        1, 32'hC0000000, 0, 1, 1, 32'h80001000, 0, 32'h0,        32'h0);
        vecs[26] = mk(0, 0, 32'h0,        1, 32'hC0000001, 0, 1, 1, 32'h80001004, 1, 32'h80001000, 32'hC0000000);
        vecs[27] = mk(0, 1, 32'h80002000, 1, 32'hC0000002, 1, 1, 1, 32'h80001008, 1, 32'h80001000, 32'hC0000000);
        vecs[28] = mk(0, 0, 32'h0,        0, 32'h0,        1, 1, 1, 32'h80002000, 0, 32'h0,        32'h0);
        vecs[29] = mk(0, 0, 32'h0,        1, 32'hA0000000, 0, 1, 1, 32'h80002000, 0, 32'h0,        32'h0);
        vecs[30] = mk(0, 0, 32'h0,        0, 32'h0,        0, 1, 1, 32'h80002004, 1, 32'h80002000, 32'hA0000000);
        // reset in FETCH with three entries queued
        vecs[31] = mk(0, 0, 32'h0,        1, 32'hA0000001, 0, 1, 1, 32'h80002004, 1, 32'h80002000, 32'hA0000000);
        vecs[32] = mk(0, 0, 32'h0,        1, 32'hA0000002, 0, 1, 1, 32'h80002008, 1, 32'h80002000, 32'hA0000000);
        vecs[33] = mk(1, 0, 32'h0,        0, 32'h0,        0, 1, 1, 32'h8000200C, 1, 32'h80002000, 32'hA0000000);
        vecs[34] = mk(0, 0, 32'h0,        0, 32'h0,        0, 1, 0, 32'h80000000, 0, 32'h0,        32'h0);
        vecs[35] = mk(0, 0, 32'h0,        0, 32'h0,        0, 1, 1, 32'h80000000, 0, 32'h0,        32'h0);
        // address wrap past the top of the address space
        vecs[36] = mk(0, 1, 32'hFFFFFFFC, 1, 32'h12345678, 1, 1, 1, 32'h80000000, 0, 32'h0,        32'h0);
        vecs[37] = mk(0, 0, 32'h0,        1, 32'hB0000000, 1, 1, 1, 32'hFFFFFFFC, 0, 32'h0,        32'h0);
        vecs[38] = mk(0, 0, 32'h0,        1, 32'hB0000001, 0, 1, 1, 32'h00000000, 1, 32'hFFFFFFFC, 32'hB0000000);
        vecs[39] = mk(0, 0, 32'h0,        0, 32'h0,        1, 1, 1, 32'h00000004, 1, 32'hFFFFFFFC, 32'hB0000000);
        vecs[40] = mk(0, 0, 32'h0,        0, 32'h0,        1, 1, 1, 32'h00000004, 1, 32'h00000000, 32'hB0000001);

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // Redirect in the IDLE cycle, then stream at one instruction per cycle.
        applyStimulus(mk(1, 0, 32'h0, 0, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0), "seq_rst");
        applyStimulus(mk(0, 1, 32'h00000103, 0, 32'h0, 1, 1, 0, 32'h80000000, 0, 32'h0, 32'h0), "seq_idle_redir");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(mk(0, 0, 32'h0, 1, 32'h50000000 + 32'(i), 1, 1, 1,
                             32'h00000100 + 32'(4 * i), (i > 0),
                             32'h00000100 + 32'(4 * (i - 1)), 32'h50000000 + 32'(i - 1)),
                          $sformatf("seq_stream%0d", i));
        end
        applyStimulus(mk(0, 0, 32'h0, 0, 32'h0, 1, 1, 1, 32'h00000118, 1, 32'h00000114, 32'h50000005), "seq_tail");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
Parametrised instruction-fetch stage and successor to the single-register fetch stage. It drives a variable-latency instruction memory through a req/ack handshake and buffers fetched instructions with their PCs in a QDEPTH-entry queue. Decode consumes the queue through a valid/ready interface. Redirects (branch, jump, exception) flush the queue and restart fetch, and correctly discard a request that is already in flight.

Parameters:
XLEN, 32, width of the PC and address.
RESET_PC, 32'h80000000, first fetch address after reset (XLEN bits).
QDEPTH, 4, number of queue entries; power of two, at least 2.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
redirect  in  1  flush the queue and restart fetch at redirect_pc.
redirect_pc  in  XLEN  redirect target; bits [1:0] are forced to 0.
im_req  out  1  instruction-memory request (registered).
im_addr  out  XLEN  request address (registered).
im_ack  in  1  memory accepts the request; im_data is valid in this cycle.
im_data  in  32  instruction word.
id_valid  out  1  queue head is valid.
id_ready  in  1  decode accepts the head; low means decode is stalled.
id_ins  out  32  head instruction.
id_pc  out  XLEN  head PC.
id_npc  out  XLEN  head PC + 4, wrapping modulo 2^XLEN.

Behaviour:
- Reset (rst=1 at an edge), highest priority over every other input:
  - im_req=0, im_addr=RESET_PC.
  - queue count=0, so id_valid=0.
  - state=IDLE; fetch_pc=RESET_PC.
- Queue:
  - circular buffer of {pc, ins}; rd_ptr/wr_ptr wrap modulo QDEPTH; count ranges 0..QDEPTH.
  - id_* outputs are driven from the head entry; id_valid = (count != 0).
  - pop when id_valid && id_ready. push when im_ack in FETCH.
  - push and pop in the same cycle leave count unchanged.
- Handshake rules:
  - While im_req=1 and im_ack=0, im_req and im_addr hold stable.
  - At most one request is outstanding.
  - im_ack may arrive in the same cycle im_req rises (zero-wait memory).
  - With ack every cycle, throughput is 1 instruction/cycle.
- Slot reservation: a request is launched only when count_next (after this cycle's push and pop) < QDEPTH. The queue therefore never overflows, and a push is never dropped except on redirect.
- FSM states: IDLE, FETCH, HOLD, DISCARD.
  - IDLE: the first cycle after reset.
    - Next: FETCH, with im_req=1 and im_addr=fetch_pc.
    - If redirect=1, fetch_pc uses redirect_pc instead.
  - FETCH (request outstanding):
    - im_ack && a slot is available: push, im_addr<=im_addr+4, im_req stays 1.
    - im_ack && no slot: push, im_req<=0, fetch_pc<=im_addr+4, go to HOLD.
    - no ack: hold.
  - HOLD: im_req=0.
    - When count_next < QDEPTH: im_req<=1, im_addr<=fetch_pc, go to FETCH.
  - DISCARD: a flushed request is still outstanding; im_req and im_addr hold.
    - On im_ack: drop im_data, im_req<=1, im_addr<=fetch_pc (the redirect target), go to FETCH.
- Redirect (any state except reset), with priority over push and pop:
  - count<=0 and both pointers reset, so id_valid=0 on the next cycle.
  - fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00}.
  - From FETCH with im_ack=0: go to DISCARD.
  - From FETCH with im_ack=1: drop the data; im_req<=1, im_addr<=target, go to FETCH.
  - From HOLD or IDLE: im_req<=1, im_addr<=target, go to FETCH.
  - From DISCARD: update fetch_pc only; remain in DISCARD.
  - Redirect-to-first-request latency is 1 cycle, unless a discard is pending.
- Arithmetic: all PC arithmetic is XLEN-bit. 0xFFFFFFFC+4 = 0x00000000 with no flag.

Test Plan:
- Reset then ack every cycle, id_ready=1: im_addr=0x80000000, 0x80000004, … on consecutive cycles; id_pc follows one cycle after each ack; id_npc=id_pc+4.
- id_ready=0, ack every cycle, QDEPTH=4: exactly 4 pushes (0x80000000..0x8000000C), then im_req=0. Release id_ready: im_req reasserts with 0x80000010 and no PC is skipped.
- 3-cycle ack latency: im_addr is stable through the wait; a redirect to 0x80001002 while waiting flushes id_valid to 0. The stale ack data is not pushed, and the next request is 0x80001000.
- Redirect coincident with im_ack and pop at count=2: count=0 next cycle; next im_addr=target; the acked word is absent from the queue.
- rst asserted mid-FETCH with count=3: next cycle id_valid=0, im_req=0; the following cycle im_req=1 with im_addr=RESET_PC.
- XLEN=32, redirect_pc=0xFFFFFFFC, ack every cycle: fetches 0xFFFFFFFC, then 0x00000000; the head's id_npc is 0x00000000.
